// File: rtl/reg_exec_seq.sv
// Multi-cycle register-register execute controller in front of a register file.
// Sequence: read Rn, read and shift Rm, run the ALU and latch flags, write Rd back.
module reg_exec_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [2:0]       rd,
    input  logic [2:0]       rn,
    input  logic [2:0]       rm,
    input  logic [1:0]       shift,
    input  logic [WIDTH-1:0] rf_data,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       flags
);
    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [2:0] {S_WAIT, S_GETA, S_GETB, S_EXEC, S_WRITE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, sh_q;
    logic [2:0]       rd_q, rn_q, rm_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       flags_q;
    logic             done_q, done_d;

    logic [WIDTH-1:0] shifted, sum, dif, res;
    logic             ovf;

    always_comb begin
        state_d = state_q;
        readnum = rn_q;
        done_d  = 1'b0;
        case (state_q)
            S_WAIT:  if (start) state_d = S_GETA;
            S_GETA:  state_d = S_GETB;
            S_GETB: begin
                readnum = rm_q;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_CMP) begin
                    state_d = S_WAIT;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_WAIT;
                done_d  = 1'b1;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        case (sh_q)
            2'b01:   shifted = {rf_data[WIDTH-2:0], 1'b0};
            2'b10:   shifted = {1'b0, rf_data[WIDTH-1:1]};
            2'b11:   shifted = {rf_data[WIDTH-1], rf_data[WIDTH-1:1]};
            default: shifted = rf_data;
        endcase
    end

    // Carry out is dropped; V comes from operand/result sign agreement.
    always_comb begin
        sum = a_q + b_q;
        dif = a_q - b_q;
        res = b_q;
        ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                res = sum;
                ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_CMP: begin
                res = dif;
                ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res = a_q & b_q;
            default: res = b_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            op_q    <= '0;
            sh_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == S_WAIT && start) begin
                op_q <= opcode;
                sh_q <= shift;
                rd_q <= rd;
                rn_q <= rn;
                rm_q <= rm;
            end
            if (state_q == S_GETA) a_q <= rf_data;
            if (state_q == S_GETB) b_q <= shifted;
            if (state_q == S_EXEC) begin
                c_q     <= res;
                flags_q <= {res[WIDTH-1], ovf, res == '0};
            end
        end
    end

    // Gating with reset_n keeps an op aborted in WRITE from landing in the register file.
    assign write    = (state_q == S_WRITE) && reset_n;
    assign writenum = rd_q;
    assign data_in  = c_q;
    assign busy     = (state_q != S_WAIT);
    assign done     = done_q;
    assign flags    = flags_q;

endmodule
